sysid_ext_avalon: RTL and testbench

- Parametrised successor to the system-ID slave: Avalon-MM slave exposing a read-only system ID, build timestamp and version word.
- Adds a read/write scratch register, a 64-bit uptime counter with atomic snapshot read, and a control/status register.
- Sits on the Qsys control bus beside the CPU; software uses it to confirm hardware/software build match and to measure elapsed time.

---
 rtl/sysid_ext_avalon.sv | 106 ++++++++++
 tb/tb_sysid_ext_avalon.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sysid_ext_avalon.sv
// Avalon-MM system-ID slave: read-only ID/timestamp/version/caps words, a byte-lane
// scratch register, and a 64-bit divided uptime counter with tear-free snapshot read.
module sysid_ext_avalon #(
    parameter logic [31:0] ID_VALUE      = 32'h64A2_1A66,
    parameter logic [31:0] TIMESTAMP     = 32'd0,
    parameter logic [31:0] VERSION       = 32'h0002_0000,
    parameter logic [31:0] SCRATCH_RESET = 32'd0,
    parameter int unsigned TICK_DIV      = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);
    localparam logic [15:0] DIV_MAX = 16'(TICK_DIV - 1);
    localparam logic [31:0] CAPS    = {16'(TICK_DIV), 15'd0, 1'b1};

    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;
    logic [31:0] scratch_q, scratch_d;
    logic [63:0] uptime_q, uptime_d;
    logic [31:0] shadow_hi_q;
    logic [15:0] div_q, div_d;
    logic        freeze_q, freeze_d;
    logic        wrap_q, wrap_d;
    logic        ctrl_wr, clr, roll;

    assign ctrl_wr = write && (address == 3'd6) && byteenable[0];
    assign clr     = ctrl_wr && writedata[1];
    assign roll    = !freeze_q && (div_q == DIV_MAX) && (&uptime_q);

    always_comb begin
        scratch_d = scratch_q;
        if (write && (address == 3'd3)) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
            end
        end

        div_d    = div_q;
        uptime_d = uptime_q;
        if (clr) begin
            div_d    = 16'd0;
            uptime_d = 64'd0;
        end else if (!freeze_q) begin
            if (div_q == DIV_MAX) begin
                div_d    = 16'd0;
                uptime_d = uptime_q + 64'd1;
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        freeze_d = ctrl_wr ? writedata[0] : freeze_q;

        // Priority low to high: W1C, then rollover set, then CLEAR.
        wrap_d = wrap_q;
        if (ctrl_wr && writedata[2]) wrap_d = 1'b0;
        if (roll)                    wrap_d = 1'b1;
        if (clr)                     wrap_d = 1'b0;

        rdata_d = 32'd0;
        case (address)
            3'd0: rdata_d = ID_VALUE;
            3'd1: rdata_d = TIMESTAMP;
            3'd2: rdata_d = VERSION;
            3'd3: rdata_d = scratch_q;
            3'd4: rdata_d = uptime_q[31:0];
            3'd5: rdata_d = shadow_hi_q;
            3'd6: rdata_d = {29'd0, wrap_q, 1'b0, freeze_q};
            3'd7: rdata_d = CAPS;
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdata_q     <= 32'd0;
            rvalid_q    <= 1'b0;
            scratch_q   <= SCRATCH_RESET;
            uptime_q    <= 64'd0;
            shadow_hi_q <= 32'd0;
            div_q       <= 16'd0;
            freeze_q    <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            rvalid_q  <= read;
            if (read) rdata_q <= rdata_d;
            // Upper word captured from the same pre-increment value as the low word returned.
            if (read && (address == 3'd4)) shadow_hi_q <= uptime_q[63:32];
            scratch_q <= scratch_d;
            uptime_q  <= uptime_d;
            div_q     <= div_d;
            freeze_q  <= freeze_d;
            wrap_q    <= wrap_d;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;
endmodule

// File: tb/tb_sysid_ext_avalon.sv
// Directed bench: two instances (TICK_DIV=1 and 4) share one bus; expected values are hand-derived.
module tb_sysid_ext_avalon;
    localparam logic [31:0] TS = 32'h2024_0601;
    localparam logic [31:0] SR = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] rd1, rd4;
    logic        rv1, rv4;
    logic [63:0] force_val;
    int          n_chk = 0;
    int          n_fail = 0;

    sysid_ext_avalon #(.TIMESTAMP(TS), .SCRATCH_RESET(SR), .TICK_DIV(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd1), .readdatavalid(rv1));

    sysid_ext_avalon #(.TIMESTAMP(TS), .SCRATCH_RESET(SR), .TICK_DIV(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd4), .readdatavalid(rv4));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge and span exactly one rising edge.
    task automatic cyc(input logic r, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        read = r; write = w; address = a; writedata = d; byteenable = be;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input string tag, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'd0, 4'd0);
        chk({tag, "_vld"}, 32'(rv1), 32'd1);
        chk(tag, rd1, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b0, 1'b1, a, d, be);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task set_up(input logic [63:0] v);
        force_val = v;
        force dut1.uptime_q = force_val;
        #1;
        release dut1.uptime_q;
    endtask

    initial begin
        @(negedge clock);
        do_reset();
        chk("rst_data", rd1, 32'd0);
        chk("rst_vld", 32'(rv1), 32'd0);
        chk("rst_data4", rd4, 32'd0);

        rd(3'd0, "id", 32'h64A2_1A66);
        rd(3'd1, "ts", TS);
        rd(3'd2, "ver", 32'h0002_0000);
        rd(3'd7, "caps1", 32'h0001_0001);
        chk("caps4", rd4, 32'h0004_0001);
        idle(1);
        chk("vld_drop", 32'(rv1), 32'd0);
        chk("hold", rd1, 32'h0001_0001);

        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        rd(3'd0, "id_ro", 32'h64A2_1A66);

        wr(3'd3, 32'hDEAD_BEEF, 4'hF);
        wr(3'd3, 32'h0000_0055, 4'b0001);
        rd(3'd3, "scr_be", 32'hDEAD_BE55);
        wr(3'd3, 32'h0077_0000, 4'b0100);
        rd(3'd3, "scr_lane2", 32'hDE77_BE55);

        do_reset();
        chk("rst2_data", rd1, 32'd0);
        idle(40);
        rd(3'd4, "up1", 32'd40);
        chk("up4", rd4, 32'd10);
        rd(3'd3, "scr_rst", SR);
        wr(3'd6, 32'd1, 4'hF);
        idle(20);
        rd(3'd4, "frz1", 32'd43);
        chk("frz4", rd4, 32'd10);
        rd(3'd6, "ctrl_frz", 32'd1);

        wr(3'd6, 32'd0, 4'hF);
        set_up(64'h0000_0000_FFFF_FFFF);
        rd(3'd4, "snap_lo", 32'hFFFF_FFFF);
        rd(3'd5, "snap_hi", 32'd0);
        rd(3'd4, "lo2", 32'd1);
        rd(3'd5, "hi2", 32'd1);

        set_up(64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        rd(3'd6, "wrap_set", 32'd4);
        wr(3'd6, 32'd4, 4'hF);
        rd(3'd6, "wrap_clr", 32'd0);

        set_up(64'hFFFF_FFFF_FFFF_FFFF);
        wr(3'd6, 32'd4, 4'hF);
        rd(3'd6, "wrap_win", 32'd4);
        wr(3'd6, 32'd5, 4'b1110);
        rd(3'd6, "ctrl_be", 32'd4);

        set_up(64'hFFFF_FFFF_FFFF_FFFF);
        wr(3'd6, 32'd2, 4'hF);
        rd(3'd6, "clr_wrap", 32'd0);
        rd(3'd4, "clr_up", 32'd1);
        wr(3'd6, 32'd2, 4'hF);
        rd(3'd4, "clr_up0", 32'd0);

        cyc(1'b1, 1'b1, 3'd3, 32'h1234_5678, 4'hF);
        chk("rw_vld", 32'(rv1), 32'd1);
        chk("rw_old", rd1, SR);
        rd(3'd3, "rw_new", 32'h1234_5678);

        reset_n = 1'b0;
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 4'd0);
        reset_n = 1'b1;
        chk("rst_rd_vld", 32'(rv1), 32'd0);
        chk("rst_rd_data", rd1, 32'd0);
        idle(1);
        chk("rst_rd_vld2", 32'(rv1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
